// File: rtl/model.sv
// Bit-reversal of a data word.
// Provides a combinational reversed copy of din plus a registered copy one
// clk later, with a flag saying whether the captured word was fully 0/1.
//
// Ports:
//   clk          - rising-edge clock for the registered outputs
//   rst          - asynchronous active-low reset (registered outputs only)
//   din          - word to reverse; may float (X/Z) between transfers
//   dout         - combinational reversal: dout[i] = din[DATA_WIDTH-1-i]
//   dout_q       - dout registered, one cycle of latency
//   dout_q_valid - dout_q was captured from a din with no X/Z bits
module model #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] dout_q,
    output logic                  dout_q_valid
);

    localparam int unsigned MSB = DATA_WIDTH - 1;

    logic din_known_c;

    // Pure wire permutation; X/Z travel bit for bit and the middle bit of an
    // odd width maps onto itself.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
        assign dout[i] = din[MSB-i];
    end

    // Only meaningful in 4-state simulation; real silicon carries just 0/1,
    // so synthesis reduces this to a constant 1.
    assign din_known_c = !$isunknown(din);

    // Registered copy; reset asserts immediately and releases on clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q       <= '0;
            dout_q_valid <= 1'b0;
        end else begin
            dout_q       <= dout;
            dout_q_valid <= din_known_c;
        end
    end

endmodule

// File: tb/tb_model.sv
// Directed bench for model: reversal values, latency, X/Z pass-through,
// asynchronous reset, involution, and an odd-width instance.
module tb_model;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] dout_q;
    logic        dout_q_valid;

    logic [31:0] inv_dout;
    logic [31:0] inv_dout_q;
    logic        inv_dout_q_valid;

    logic [4:0]  din5;
    logic [4:0]  dout5;
    logic [4:0]  dout5_q;
    logic        dout5_q_valid;

    int unsigned vectors;
    int unsigned miscompares;

    logic [31:0] zword;
    logic        exp_zvalid;

    model #(.DATA_WIDTH(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .dout         (dout),
        .dout_q       (dout_q),
        .dout_q_valid (dout_q_valid)
    );

    // Reversing the reversal must give din back.
    model #(.DATA_WIDTH(32)) u_inv (
        .clk          (clk),
        .rst          (rst),
        .din          (dout),
        .dout         (inv_dout),
        .dout_q       (inv_dout_q),
        .dout_q_valid (inv_dout_q_valid)
    );

    model #(.DATA_WIDTH(5)) u_dut5 (
        .clk          (clk),
        .rst          (rst),
        .din          (din5),
        .dout         (dout5),
        .dout_q       (dout5_q),
        .dout_q_valid (dout5_q_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] WALK_IN  [3] = '{32'h0000_0002, 32'h0000_0004, 32'h0000_0008};
    localparam logic [31:0] WALK_OUT [3] = '{32'h4000_0000, 32'h2000_0000, 32'h1000_0000};
    localparam logic [31:0] PAT_IN   [3] = '{32'hA5A5_0F0F, 32'hFFFF_FFFF, 32'h0000_0000};
    localparam logic [31:0] PAT_OUT  [3] = '{32'hF0F0_A5A5, 32'hFFFF_FFFF, 32'h0000_0000};

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        din         = 32'h0;
        din5        = 5'b0;
        zword       = 'z;
        // A simulator that cannot hold Z stores a known value instead.
        exp_zvalid  = $isunknown(zword) ? 1'b0 : 1'b1;

        // Reset holds the registers low even while clk runs.
        #22;
        check("rst_dout_q", dout_q, 32'h0);
        check("rst_valid", 32'(dout_q_valid), 32'h0);
        din = 32'h0000_0001;
        #1;
        check("rst_dout_comb", dout, 32'h8000_0000);

        // Release between edges; nothing captured until the next edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_no_capture", dout_q, 32'h0);
        step();
        check("first_dout_q", dout_q, 32'h8000_0000);
        check("first_valid", 32'(dout_q_valid), 32'h1);

        for (int i = 0; i < 3; i++) begin
            din = WALK_IN[i];
            #1;
            check("walk_dout", dout, WALK_OUT[i]);
            check("walk_dout_q_prev", dout_q, (i == 0) ? 32'h8000_0000 : WALK_OUT[i-1]);
            step();
            check("walk_dout_q", dout_q, WALK_OUT[i]);
        end

        for (int i = 0; i < 3; i++) begin
            din = PAT_IN[i];
            #1;
            check("pat_dout", dout, PAT_OUT[i]);
            check("pat_involution", inv_dout, PAT_IN[i]);
            step();
            check("pat_dout_q", dout_q, PAT_OUT[i]);
            check("pat_valid", 32'(dout_q_valid), 32'h1);
        end

        // Floating bus between transfers.
        din = zword;
        #1;
        check("z_dout", dout, zword);
        step();
        check("z_dout_q", dout_q, zword);
        check("z_valid", 32'(dout_q_valid), 32'(exp_zvalid));

        // Mid-stream reset pulse.
        din = 32'h0000_0001;
        step();
        check("pre_pulse_dout_q", dout_q, 32'h8000_0000);
        #2;
        rst = 1'b0;
        #1;
        check("pulse_dout_q", dout_q, 32'h0);
        check("pulse_valid", 32'(dout_q_valid), 32'h0);
        check("pulse_dout", dout, 32'h8000_0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("pulse_release_hold", dout_q, 32'h0);
        step();
        check("resume_dout_q", dout_q, 32'h8000_0000);
        check("resume_valid", 32'(dout_q_valid), 32'h1);

        // Odd width: middle bit maps to itself.
        din5 = 5'b00110;
        #1;
        check("w5_dout", 32'(dout5), 32'h0000_000C);
        step();
        check("w5_dout_q", 32'(dout5_q), 32'h0000_000C);
        din5 = 5'b00100;
        #1;
        check("w5_middle", 32'(dout5), 32'h0000_0004);
        din5 = 5'b10001;
        #1;
        check("w5_ends", 32'(dout5), 32'h0000_0011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/model.md
MODEL -- requirements
Module: model

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be legal for any value >= 1.
REQ-002 Port clk, input, 1, rising-edge clock for the registered output only.
REQ-003 Port rst, input, 1, reset; asynchronous, active-low; clock clk.
REQ-004 Port din, input, DATA_WIDTH, word to be bit-reversed; may be all-Z or undriven between transfers.
REQ-005 Port dout, output, DATA_WIDTH, combinational bit-reversal of din.
REQ-006 Port dout_q, output, DATA_WIDTH, registered bit-reversal of din, one clk later.
REQ-007 Port dout_q_valid, output, 1, high when dout_q holds a word captured from a fully 0/1 din.

Function
REQ-008 dout[i] SHALL equal din[DATA_WIDTH-1-i] for every i in 0..DATA_WIDTH-1.
REQ-009 dout SHALL have zero-cycle latency: a pure wire permutation, no clock, no reset dependency.
REQ-010 dout SHALL be valid in the same cycle din changes, and stable while din is stable.
REQ-011 The permutation SHALL preserve per-bit X/Z in simulation: a Z on din[j] appears as Z on dout[DATA_WIDTH-1-j].
REQ-012 For odd DATA_WIDTH, the middle bit SHALL map to itself.
REQ-013 The reversal SHALL be an involution: reversing dout again SHALL reproduce din exactly.
REQ-014 On each rising clk edge with rst high, dout_q SHALL load the reversal of din.
REQ-015 dout_q SHALL therefore equal the dout value of the previous cycle, a latency of exactly 1 cycle.
REQ-016 On that same edge, dout_q_valid SHALL load 1 if every din bit is 0 or 1, else 0.
REQ-017 A din containing any X or Z bit SHALL still be captured into dout_q bit for bit, with dout_q_valid 0.
REQ-018 The block SHALL contain no arithmetic, no state machine and no handshake; din is accepted unconditionally every cycle.
REQ-019 The block SHALL contain no internal state other than the dout_q and dout_q_valid registers.

Reset
REQ-020 While rst is low, dout_q SHALL be all zeros and dout_q_valid SHALL be 0, independent of clk.
REQ-021 Assertion of rst SHALL take effect immediately (asynchronously), including mid-stream.
REQ-022 Release of rst SHALL be synchronous to clk: the first capture happens on the first rising edge after rst goes high.
REQ-023 The dout combinational path SHALL be unaffected by rst.

Verification
REQ-024 DATA_WIDTH=32, din=0x00000001 -> dout=0x80000000 same cycle; dout_q=0x80000000 and dout_q_valid=1 after the next edge.
REQ-025 Walking one, din=0x2, 0x4, 0x8 one per transfer -> dout=0x40000000, 0x20000000, 0x10000000 respectively.
REQ-026 din all-Z between transfers -> dout all-Z; dout_q all-Z and dout_q_valid=0 after the next edge.
REQ-027 din=0xA5A5_0F0F -> dout=0xF0F0_A5A5; din=0xFFFFFFFF -> 0xFFFFFFFF; din=0 -> 0.
REQ-028 Pulse rst low mid-stream while din=0x00000001 -> dout_q=0 and dout_q_valid=0 immediately; dout stays 0x80000000; capture resumes on the first edge after release.
REQ-029 DATA_WIDTH=5, din=5'b00110 -> dout=5'b01100; middle bit is unchanged.
